bandit_ctrl_fsm: RTL and testbench

//   Top-level game sequencer for the one-arm bandit. Consumes debounced key pulses and
//   the coin counter value; drives cur_state to the coin counter and the display/reel

---
 rtl/bandit_ctrl_fsm.sv | 127 ++++++++++++
 tb/tb_bandit_ctrl_fsm.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bandit_ctrl_fsm.sv
// Game sequencer for the one-arm bandit: walks WELCOME/COIN/GAME/SCORE/ERROR,
// charges one coin per game with a single-cycle pulse and runs the reels
// exactly while a game is in progress.
module bandit_ctrl_fsm #(
    parameter int unsigned COIN_IDLE_CYCLES = 500_000_000,
    parameter int unsigned GAME_MAX_CYCLES  = 1_000_000_000,
    parameter int unsigned SCORE_CYCLES     = 300_000_000,
    parameter int unsigned ERR_CYCLES       = 200_000_000,
    parameter int unsigned TMR_W            = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_key_p,
    input  logic       coin_p,
    input  logic       start_p,
    input  logic       stop_p,
    input  logic [3:0] coin_num,
    output logic [3:0] cur_state,
    output logic       coin_minus_p,
    output logic       reel_run
);

    localparam logic [3:0] ST_WELCOME = 4'b0000;
    localparam logic [3:0] ST_GAME    = 4'b0001;
    localparam logic [3:0] ST_SCORE   = 4'b0010;
    localparam logic [3:0] ST_ERROR   = 4'b0011;
    localparam logic [3:0] ST_COIN    = 4'b0100;

    // Timer value on the final cycle of each timed state
    localparam logic [TMR_W-1:0] COIN_LAST  = TMR_W'(COIN_IDLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAME_LAST  = TMR_W'(GAME_MAX_CYCLES - 1);
    localparam logic [TMR_W-1:0] SCORE_LAST = TMR_W'(SCORE_CYCLES - 1);
    localparam logic [TMR_W-1:0] ERR_LAST   = TMR_W'(ERR_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_MAX    = '1;
    localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);

    logic [3:0]       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             coin_minus_q, coin_minus_d;
    logic             reel_run_q, reel_run_d;
    logic             timer_clr;

    // Next-state selection; start_p outranks coin_key_p, which outranks timeouts
    always_comb begin
        state_d   = ST_WELCOME;
        timer_clr = 1'b0;
        case (state_q)
            ST_WELCOME: begin
                state_d = ST_WELCOME;
                if (start_p) begin
                    state_d = (coin_num != 4'd0) ? ST_GAME : ST_ERROR;
                end else if (coin_key_p) begin
                    state_d = ST_COIN;
                end
            end
            ST_COIN: begin
                state_d = ST_COIN;
                if (start_p) begin
                    state_d = (coin_num != 4'd0) ? ST_GAME : ST_ERROR;
                end else if (coin_key_p) begin
                    state_d = ST_WELCOME;
                end else if (timer_q == COIN_LAST) begin
                    state_d = ST_WELCOME;
                end else if (coin_p) begin
                    timer_clr = 1'b1;
                end
            end
            ST_GAME: begin
                state_d = ST_GAME;
                if (stop_p || (timer_q == GAME_LAST)) begin
                    state_d = ST_SCORE;
                end
            end
            ST_SCORE: begin
                state_d = ST_SCORE;
                if (timer_q == SCORE_LAST) begin
                    state_d = ST_WELCOME;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
                if (timer_q == ERR_LAST) begin
                    state_d = ST_WELCOME;
                end
            end
            default: begin
                state_d = ST_WELCOME;
            end
        endcase
    end

    // Dwell timer: restarts on any state change or coin activity, otherwise counts and saturates
    always_comb begin
        timer_d = timer_q;
        if ((state_d != state_q) || timer_clr) begin
            timer_d = '0;
        end else if (timer_q != TMR_MAX) begin
            timer_d = timer_q + TMR_ONE;
        end
    end

    // Outputs are derived from the upcoming state so they register together with it
    always_comb begin
        coin_minus_d = (state_d == ST_GAME) && (state_q != ST_GAME);
        reel_run_d   = (state_d == ST_GAME);
    end

    // State, timer and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_WELCOME;
            timer_q      <= '0;
            coin_minus_q <= 1'b0;
            reel_run_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            coin_minus_q <= coin_minus_d;
            reel_run_q   <= reel_run_d;
        end
    end

    assign cur_state    = state_q;
    assign coin_minus_p = coin_minus_q;
    assign reel_run     = reel_run_q;

endmodule

// File: tb/tb_bandit_ctrl_fsm.sv
// Self-checking bench for the bandit sequencer: directed scenarios plus a random
// phase, every cycle compared against a countdown-based behavioural model.
module tb_bandit_ctrl_fsm;

    localparam int COIN_N  = 12;
    localparam int GAME_N  = 16;
    localparam int SCORE_N = 10;
    localparam int ERR_N   = 9;

    localparam int S_WELCOME = 0;
    localparam int S_GAME    = 1;
    localparam int S_SCORE   = 2;
    localparam int S_ERROR   = 3;
    localparam int S_COIN    = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin_key_p = 1'b0;
    logic       coin_p = 1'b0;
    logic       start_p = 1'b0;
    logic       stop_p = 1'b0;
    logic [3:0] coin_num;
    logic [3:0] cur_state;
    logic       coin_minus_p;
    logic       reel_run;

    int checks = 0;
    int errors = 0;

    // Behavioural model: current state and the number of cycles it still has to run
    int m_state = S_WELCOME;
    int m_left  = 0;
    bit exp_minus = 1'b0;

    // Coin counter stand-in driving coin_num; a charge lands two edges after the pulse
    int credit = 0;
    bit pend1 = 1'b0;
    bit pend2 = 1'b0;

    int state_cycles [0:15];
    int minus_seen = 0;

    assign coin_num = 4'(credit);

    bandit_ctrl_fsm #(
        .COIN_IDLE_CYCLES(COIN_N),
        .GAME_MAX_CYCLES (GAME_N),
        .SCORE_CYCLES    (SCORE_N),
        .ERR_CYCLES      (ERR_N),
        .TMR_W           (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .coin_key_p  (coin_key_p),
        .coin_p      (coin_p),
        .start_p     (start_p),
        .stop_p      (stop_p),
        .coin_num    (coin_num),
        .cur_state   (cur_state),
        .coin_minus_p(coin_minus_p),
        .reel_run    (reel_run)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    // How long a state lasts once entered (0 = untimed)
    function automatic int durationOf(input int s);
        case (s)
            S_COIN:  return COIN_N;
            S_GAME:  return GAME_N;
            S_SCORE: return SCORE_N;
            S_ERROR: return ERR_N;
            default: return 0;
        endcase
    endfunction

    // Single comparison point: counts every check, reports mismatches
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Advance the model across one clock edge given the pulses present during the cycle
    task automatic modelStep(input bit st, input bit sp, input bit ck, input bit cp);
        int  nxt;
        bit  restart;
        bool_last: begin end
        nxt     = m_state;
        restart = 1'b0;
        if (m_state == S_WELCOME || m_state == S_COIN) begin
            if (st)
                nxt = (credit != 0) ? S_GAME : S_ERROR;
            else if (ck)
                nxt = (m_state == S_WELCOME) ? S_COIN : S_WELCOME;
            else if (m_state == S_COIN && m_left == 1)
                nxt = S_WELCOME;
            else if (m_state == S_COIN && cp)
                restart = 1'b1;
        end else if (m_state == S_GAME) begin
            if (sp || m_left == 1)
                nxt = S_SCORE;
        end else begin
            if (m_left == 1)
                nxt = S_WELCOME;
        end
        exp_minus = (nxt == S_GAME) && (m_state != S_GAME);
        if (nxt != m_state)
            m_left = durationOf(nxt);
        else if (restart)
            m_left = COIN_N;
        else if (m_left > 1)
            m_left = m_left - 1;
        m_state = nxt;
        if (pend2 && credit > 0)
            credit = credit - 1;
        if (cp && credit < 9)
            credit = credit + 1;
        pend2 = pend1;
        pend1 = exp_minus;
    endtask

    // Drive one cycle of pulses, step the model and compare all outputs after the edge
    task automatic applyStimulus(input bit st, input bit sp, input bit ck, input bit cp);
        start_p    = st;
        stop_p     = sp;
        coin_key_p = ck;
        coin_p     = cp;
        @(posedge clk);
        #1;
        modelStep(st, sp, ck, cp);
        start_p    = 1'b0;
        stop_p     = 1'b0;
        coin_key_p = 1'b0;
        coin_p     = 1'b0;
        checkOutput("cur_state", int'(cur_state), m_state);
        checkOutput("coin_minus_p", int'(coin_minus_p), int'(exp_minus));
        checkOutput("reel_run", int'(reel_run), (m_state == S_GAME) ? 1 : 0);
        state_cycles[cur_state]++;
        if (coin_minus_p)
            minus_seen++;
    endtask

    task automatic runIdle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clearCounts();
        for (int i = 0; i < 16; i++)
            state_cycles[i] = 0;
        minus_seen = 0;
    endtask

    // Step idle cycles until the DUT is back in WELCOME, with a bounded budget
    task automatic waitWelcome();
        for (int i = 0; i < 80 && cur_state != 4'(S_WELCOME); i++)
            runIdle(1);
        checkOutput("reach_welcome", int'(cur_state), S_WELCOME);
    endtask

    // Main sequence of directed scenarios, random phase and mid-game reset
    initial begin
        clearCounts();
        #1;
        checkOutput("rst_state", int'(cur_state), S_WELCOME);
        checkOutput("rst_minus", int'(coin_minus_p), 0);
        checkOutput("rst_reel", int'(reel_run), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        runIdle(3);

        $display("[TB] start with no credit -> ERROR");
        clearCounts();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        runIdle(ERR_N + 2);
        checkOutput("err_cycles", state_cycles[S_ERROR], ERR_N);
        checkOutput("err_minus", minus_seen, 0);

        $display("[TB] insert three coins and play");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        clearCounts();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        runIdle(2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("game_minus", minus_seen, 1);
        checkOutput("game_len_stop", state_cycles[S_GAME], 5);
        clearCounts();
        runIdle(SCORE_N + 1);
        checkOutput("score_cycles", state_cycles[S_SCORE], SCORE_N - 1);

        $display("[TB] game without stop times out");
        clearCounts();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        runIdle(GAME_N + 1);
        checkOutput("game_max_cycles", state_cycles[S_GAME], GAME_N);
        waitWelcome();

        $display("[TB] coin mode idle timeout and restart");
        clearCounts();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        runIdle(COIN_N + 2);
        checkOutput("coin_idle", state_cycles[S_COIN], COIN_N);
        clearCounts();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        runIdle(COIN_N - 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        runIdle(COIN_N + 2);
        checkOutput("coin_restart", state_cycles[S_COIN], 2 * COIN_N - 1);

        $display("[TB] simultaneous start and coin key with one credit");
        credit = 1;
        clearCounts();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        runIdle(3);
        checkOutput("simul_minus", minus_seen, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        waitWelcome();

        $display("[TB] random phase");
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 19) == 0),
                          ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 14) == 0),
                          ($urandom_range(0, 5) == 0));
        end
        waitWelcome();

        $display("[TB] reset in the middle of a game");
        credit = 5;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        runIdle(4);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_state", int'(cur_state), S_WELCOME);
        checkOutput("midrst_reel", int'(reel_run), 0);
        checkOutput("midrst_minus", int'(coin_minus_p), 0);
        @(negedge clk);
        @(negedge clk);
        rst     = 1'b0;
        m_state = S_WELCOME;
        m_left  = 0;
        pend1   = 1'b0;
        pend2   = 1'b0;
        clearCounts();
        runIdle(3);
        checkOutput("post_rst_minus", minus_seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
